// File: rtl/axi_sram_resp.sv
// axi_sram_resp: single-outstanding AXI-style slave in front of a 64-bit SRAM.
//
// Only one transaction is in flight at a time. Reads wait a fixed latency of
// RD_LAT cycles before responding. Writes take an address beat, then one data
// beat with byte strobes, then a write response. Addresses outside the window
// [BASE, BASE + 8*2^DEPTH_LOG2) get an error response (2'b10). Out-of-range
// reads return zero data, and out-of-range writes do not touch the array.
//
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-low reset
//   araddr/arvalid/arready         read address channel
//   rdata/rresp/rvalid/rready      read data channel
//   awaddr/awvalid/awready         write address channel
//   wdata/wstrb/wvalid/wready      write data channel (wstrb[i] enables byte lane i)
//   bresp/bvalid/bready            write response channel
module axi_sram_resp #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_LAT     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          WORDS    = 1 << DEPTH_LOG2;
  // Byte span of the array, kept one bit wider so it never wraps.
  localparam logic [32:0] SPAN     = 33'(longint'(WORDS) * 8);
  localparam logic [3:0]  LAT_INIT = 4'(RD_LAT - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] RD_RESP = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;

  logic [63:0] mem [0:WORDS-1];

  logic                  ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic                  load_rdata;
  logic [31:0]           rd_addr, rd_off, wr_off;
  logic                  rd_hit, wr_hit;
  logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;

  // Every ready/valid is qualified by reset so that all channels are quiet
  // while reset is held low, whatever state the register still holds.
  assign arready = reset && (state_q == IDLE);
  assign awready = reset && (state_q == IDLE) && !arvalid;
  assign wready  = reset && (state_q == WR_DATA);
  assign rvalid  = reset && (state_q == RD_RESP);
  assign bvalid  = reset && (state_q == WR_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign bresp   = bresp_q;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid && rready;
  assign b_hs  = bvalid && bready;

  // When RD_LAT is 1, the read data is fetched in the same cycle as the AR
  // handshake. In that case the live araddr is used rather than the latched
  // copy.
  assign rd_addr = (state_q == IDLE) ? araddr : addr_q;
  assign rd_off  = rd_addr - BASE;
  assign rd_hit  = {1'b0, rd_off} < SPAN;
  assign rd_idx  = rd_off[DEPTH_LOG2+2:3];

  assign wr_off  = addr_q - BASE;
  assign wr_hit  = {1'b0, wr_off} < SPAN;
  assign wr_idx  = wr_off[DEPTH_LOG2+2:3];

  // Transaction sequencing. The read data is captured on the edge where
  // rvalid rises and then held until the R handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bresp_d    = bresp_q;
    load_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          addr_d = araddr;
          cnt_d  = LAT_INIT;
          if (RD_LAT == 1) begin
            state_d    = RD_RESP;
            load_rdata = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (aw_hs) begin
          addr_d  = awaddr;
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RD_RESP;
          load_rdata = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_RESP: begin
        if (r_hs) state_d = IDLE;
      end
      WR_DATA: begin
        if (w_hs) begin
          bresp_d = wr_hit ? 2'b00 : 2'b10;
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load_rdata) begin
      rdata_d = rd_hit ? mem[rd_idx] : 64'd0;
      rresp_d = rd_hit ? 2'b00 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      rdata_q <= 64'd0;
      rresp_q <= 2'b00;
      bresp_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  // The array is deliberately not reset.
  // w_hs already includes reset, because wready is qualified by reset above.
  always_ff @(posedge clock) begin
    if (w_hs && wr_hit) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_resp.sv
// tb_axi_sram_resp: self-checking bench for axi_sram_resp (RD_LAT = 3).
// Directed scenarios plus randomized traffic checked against a sparse
// word-level memory model.
module tb_axi_sram_resp;

  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam int          DEPTH_LOG2 = 10;
  localparam int          RD_LAT     = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests = 0;
  int fails = 0;
  bit timeout_flag = 1'b0;

  logic [63:0] model_mem [int];

  axi_sram_resp #(.BASE(BASE), .DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Address window check done with wide arithmetic, independent of the RTL.
  function automatic bit model_hit(input logic [31:0] a);
    longint unsigned lo, hi, x;
    lo = longint'(BASE);
    hi = lo + 64'd8 * (64'd1 << DEPTH_LOG2);
    x  = longint'(a);
    return (x >= lo) && (x < hi);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return 64'd0;
    if (model_mem.exists(model_idx(a))) return model_mem[model_idx(a)];
    return 64'hx;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    int idx;
    if (!model_hit(a)) return;
    idx = model_idx(a);
    w = model_mem.exists(idx) ? model_mem[idx] : 64'hx;
    for (int i = 0; i < 8; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model_mem[idx] = w;
  endtask

  // Driver tasks: they start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    awaddr = a; awvalid = 1'b1;
    n = 0; @(negedge clock);
    while (!awready && n < 20) begin @(negedge clock); n++; end
    if (!awready) timeout_flag = 1'b1;
    @(posedge clock); #1 awvalid = 1'b0; awaddr = $urandom;
    wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0; @(negedge clock);
    while (!wready && n < 20) begin @(negedge clock); n++; end
    if (!wready) timeout_flag = 1'b1;
    @(posedge clock); #1 wvalid = 1'b0; wdata = {$urandom, $urandom}; wstrb = 8'($urandom);
    bready = 1'b1;
    n = 0; @(negedge clock);
    while (!bvalid && n < 20) begin @(negedge clock); n++; end
    if (!bvalid) timeout_flag = 1'b1;
    resp = bresp;
    @(posedge clock); #1 bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rdelay,
                         output logic [63:0] data, output logic [1:0] resp);
    int n;
    data = 64'hx; resp = 2'bxx;
    araddr = a; arvalid = 1'b1;
    n = 0; @(negedge clock);
    while (!arready && n < 20) begin @(negedge clock); n++; end
    if (!arready) timeout_flag = 1'b1;
    @(posedge clock); #1 arvalid = 1'b0; araddr = $urandom;
    repeat (rdelay) @(posedge clock);
    #1 rready = 1'b1;
    n = 0; @(negedge clock);
    while (!rvalid && n < 30) begin @(negedge clock); n++; end
    if (!rvalid) timeout_flag = 1'b1;
    data = rdata; resp = rresp;
    @(posedge clock); #1 rready = 1'b0;
  endtask

  task automatic check_timeouts(input string name);
    tests++;
    if (timeout_flag) begin
      fails++;
      $display("[TB] FAIL %s_handshake_timeout: got timeout, expected all handshakes", name);
      timeout_flag = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_handshakes: got %b, expected 00000", {arready, awready, wready, rvalid, bvalid});
    end
    tests++;
    if (rdata !== 64'd0) begin
      fails++; $display("[TB] FAIL reset_rdata: got %h, expected 0", rdata);
    end
    tests++;
    if ({rresp, bresp} !== 4'b0) begin
      fails++; $display("[TB] FAIL reset_resp: got %b, expected 0000", {rresp, bresp});
    end
    arvalid = 1'b1; araddr = BASE;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    tests++;
    if ({arready, awready} !== 2'b10) begin
      fails++; $display("[TB] FAIL post_reset_ready_arvalid: got %b, expected 10", {arready, awready});
    end
    arvalid = 1'b0;
    #1;
    tests++;
    if (awready !== 1'b1) begin
      fails++; $display("[TB] FAIL post_reset_awready: got %b, expected 1", awready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_spec_vectors();
    logic [1:0] r; logic [63:0] d;
    do_write(32'h8000_0010, 64'h1122334455667788, 8'hFF, r);
    model_write(32'h8000_0010, 64'h1122334455667788, 8'hFF);
    tests++;
    if (r !== 2'b00) begin fails++; $display("[TB] FAIL vec_full_bresp: got %b, expected 00", r); end
    do_read(32'h8000_0010, 0, d, r);
    tests++;
    if (d !== 64'h1122334455667788) begin fails++; $display("[TB] FAIL vec_full_rdata: got %h, expected 1122334455667788", d); end
    tests++;
    if (r !== 2'b00) begin fails++; $display("[TB] FAIL vec_full_rresp: got %b, expected 00", r); end
    do_write(32'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, r);
    model_write(32'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    tests++;
    if (r !== 2'b00) begin fails++; $display("[TB] FAIL vec_partial_bresp: got %b, expected 00", r); end
    do_read(32'h8000_0010, 1, d, r);
    tests++;
    if (d !== 64'h11223344AAAAAAAA) begin fails++; $display("[TB] FAIL vec_partial_rdata: got %h, expected 11223344aaaaaaaa", d); end
    do_write(32'h8000_0010, 64'h5555555555555555, 8'h00, r);
    tests++;
    if (r !== 2'b00) begin fails++; $display("[TB] FAIL vec_nostrb_bresp: got %b, expected 00", r); end
    do_read(32'h8000_0010, 0, d, r);
    tests++;
    if (d !== 64'h11223344AAAAAAAA) begin fails++; $display("[TB] FAIL vec_nostrb_rdata: got %h, expected 11223344aaaaaaaa", d); end
    check_timeouts("spec_vectors");
  endtask

  task automatic test_latency();
    int bad_lat, bad_hold;
    bad_lat = 0; bad_hold = 0;
    rready = 1'b0; araddr = 32'h8000_0010; arvalid = 1'b1;
    @(negedge clock);
    tests++;
    if (arready !== 1'b1) begin fails++; $display("[TB] FAIL lat_arready_idle: got %b, expected 1", arready); end
    @(posedge clock); #1 arvalid = 1'b0;
    for (int i = 0; i < RD_LAT + 1; i++) begin
      @(negedge clock);
      if (rvalid !== (i == RD_LAT) || arready !== 1'b0) bad_lat++;
    end
    tests++;
    if (bad_lat != 0) begin fails++; $display("[TB] FAIL lat_rvalid_timing: got %0d bad cycles, expected 0", bad_lat); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rvalid !== 1'b1 || rdata !== 64'h11223344AAAAAAAA || rresp !== 2'b00 || arready !== 1'b0) bad_hold++;
    end
    tests++;
    if (bad_hold != 0) begin fails++; $display("[TB] FAIL lat_hold_stable: got %0d bad cycles, expected 0", bad_hold); end
    @(posedge clock); #1 rready = 1'b1;
    @(posedge clock); #1 rready = 1'b0;
    @(negedge clock);
    tests++;
    if ({rvalid, arready} !== 2'b01) begin fails++; $display("[TB] FAIL lat_after_rhs: got %b, expected 01", {rvalid, arready}); end
    @(posedge clock); #1;
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [63:0] d;
    do_read(32'h7FFF_FFF8, 0, d, r);
    tests++;
    if ({r, d} !== {2'b10, 64'd0}) begin fails++; $display("[TB] FAIL oor_below_read: got %b/%h, expected 10/0", r, d); end
    do_write(BASE, 64'h0123456789ABCDEF, 8'hFF, r);
    model_write(BASE, 64'h0123456789ABCDEF, 8'hFF);
    do_write(32'h8000_2000, 64'hDEADBEEFDEADBEEF, 8'hFF, r);
    tests++;
    if (r !== 2'b10) begin fails++; $display("[TB] FAIL oor_write_bresp: got %b, expected 10", r); end
    do_read(BASE, 0, d, r);
    tests++;
    if (d !== 64'h0123456789ABCDEF) begin fails++; $display("[TB] FAIL oor_word0_intact: got %h, expected 0123456789abcdef", d); end
    do_write(32'h8000_1FF8, 64'hCAFEF00D12345678, 8'hFF, r);
    model_write(32'h8000_1FF8, 64'hCAFEF00D12345678, 8'hFF);
    do_read(32'h8000_1FFF, 2, d, r);
    tests++;
    if ({r, d} !== {2'b00, 64'hCAFEF00D12345678}) begin fails++; $display("[TB] FAIL top_word_read: got %b/%h, expected 00/cafef00d12345678", r, d); end
    do_read(32'h8000_2000, 0, d, r);
    tests++;
    if ({r, d} !== {2'b10, 64'd0}) begin fails++; $display("[TB] FAIL oor_above_read: got %b/%h, expected 10/0", r, d); end
    check_timeouts("out_of_range");
  endtask

  task automatic test_priority();
    logic [63:0] d, expd; logic [1:0] r; int n, aw_leak;
    aw_leak = 0;
    expd = model_read(32'h8000_0010);
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = BASE + 32'h40; awvalid = 1'b1;
    #1;
    tests++;
    if ({arready, awready} !== 2'b10) begin fails++; $display("[TB] FAIL prio_ready: got %b, expected 10", {arready, awready}); end
    @(posedge clock); #1 arvalid = 1'b0; rready = 1'b1;
    n = 0; @(negedge clock);
    while (!rvalid && n < 30) begin if (awready) aw_leak++; @(negedge clock); n++; end
    if (!rvalid) timeout_flag = 1'b1;
    d = rdata;
    @(posedge clock); #1 rready = 1'b0;
    tests++;
    if (d !== expd) begin fails++; $display("[TB] FAIL prio_read_first: got %h, expected %h", d, expd); end
    tests++;
    if (aw_leak != 0) begin fails++; $display("[TB] FAIL prio_awready_during_read: got %0d cycles, expected 0", aw_leak); end
    do_write(BASE + 32'h40, 64'hFEDCBA9876543210, 8'hFF, r);
    model_write(BASE + 32'h40, 64'hFEDCBA9876543210, 8'hFF);
    tests++;
    if (r !== 2'b00) begin fails++; $display("[TB] FAIL prio_write_bresp: got %b, expected 00", r); end
    do_read(BASE + 32'h40, 0, d, r);
    tests++;
    if (d !== 64'hFEDCBA9876543210) begin fails++; $display("[TB] FAIL prio_write_data: got %h, expected fedcba9876543210", d); end
    check_timeouts("priority");
  endtask

  task automatic test_reset_abort();
    logic [63:0] d; logic [1:0] r; int bad;
    bad = 0;
    rready = 1'b0; araddr = BASE; arvalid = 1'b1;
    @(posedge clock); #1 arvalid = 1'b0; reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    tests++;
    if (arready !== 1'b1) begin fails++; $display("[TB] FAIL abort_idle_after_release: got %b, expected 1", arready); end
    for (int i = 0; i < 6; i++) begin
      if (rvalid !== 1'b0) bad++;
      @(negedge clock);
    end
    tests++;
    if (bad != 0) begin fails++; $display("[TB] FAIL abort_no_rvalid: got %0d cycles, expected 0", bad); end
    @(posedge clock); #1;
    do_write(BASE + 32'h18, 64'h0F0F0F0F0F0F0F0F, 8'hFF, r);
    model_write(BASE + 32'h18, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    awaddr = BASE + 32'h18; awvalid = 1'b1;
    @(posedge clock); #1 awvalid = 1'b0;
    reset = 1'b0; wvalid = 1'b1; wdata = 64'hF0F0F0F0F0F0F0F0; wstrb = 8'hFF;
    @(posedge clock); #1 reset = 1'b1; wvalid = 1'b0;
    @(negedge clock);
    tests++;
    if ({bvalid, wready, arready} !== 3'b001) begin fails++; $display("[TB] FAIL abort_write_idle: got %b, expected 001", {bvalid, wready, arready}); end
    @(posedge clock); #1;
    do_read(BASE + 32'h18, 0, d, r);
    tests++;
    if (d !== 64'h0F0F0F0F0F0F0F0F) begin fails++; $display("[TB] FAIL abort_word_intact: got %h, expected 0f0f0f0f0f0f0f0f", d); end
    check_timeouts("reset_abort");
  endtask

  task automatic test_random();
    logic [31:0] a; logic [63:0] d, expd; logic [7:0] s; logic [1:0] r, expr;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      do_write(BASE + 32'(i * 8), d, 8'hFF, r);
      model_write(BASE + 32'(i * 8), d, 8'hFF);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'(8 * $urandom_range(1, 4));
          1: a = BASE + 32'h2000 + 32'(8 * $urandom_range(0, 4));
          2: a = 32'h0000_1000;
          default: a = 32'hFFFF_FFF8;
        endcase
      end else begin
        a = BASE + 32'(8 * $urandom_range(0, 15)) + 32'($urandom_range(0, 7));
      end
      expr = model_hit(a) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        d = {$urandom, $urandom};
        s = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        do_write(a, d, s, r);
        model_write(a, d, s);
        tests++;
        if (r !== expr) begin fails++; $display("[TB] FAIL rand_bresp @%h: got %b, expected %b", a, r, expr); end
      end else begin
        expd = model_read(a);
        do_read(a, $urandom_range(0, 3), d, r);
        tests++;
        if ({r, d} !== {expr, expd}) begin fails++; $display("[TB] FAIL rand_read @%h: got %b/%h, expected %b/%h", a, r, d, expr, expd); end
      end
    end
    check_timeouts("random");
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_latency();
    test_out_of_range();
    test_priority();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
